pong_state_reader: RTL

//  Host-side reader for the pong core's multiplexed state port. Drives the 2-bit output-select

---
 rtl/pong_pkg.sv | 15 +
 rtl/pong_state_reader_if.sv | 30 +++
 rtl/pong_settle_timer.sv | 35 +++
 rtl/pong_state_reader.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Select codes shared with the pong core, and the reader FSM state encoding.
package pong_pkg;

    localparam logic [1:0] SEL_BALL_X    = 2'd0;
    localparam logic [1:0] SEL_BALL_Y    = 2'd1;
    localparam logic [1:0] SEL_LEFT_PAD  = 2'd2;
    localparam logic [1:0] SEL_RIGHT_PAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/pong_state_reader_if.sv
// Reader <-> core/consumer signal bundle; master is the reader, slave is its environment.
interface pong_state_reader_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic [1:0]        sel_out;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ball_x;
    logic [DATA_W-1:0] ball_y;
    logic [DATA_W-1:0] left_paddle_y;
    logic [DATA_W-1:0] right_paddle_y;
    logic              frame_valid;
    logic              frame_ready;
    logic              overrun;
    logic [7:0]        frame_count;
    logic              busy;

    modport master (
        input  enable, data_in, frame_ready,
        output sel_out, ball_x, ball_y, left_paddle_y, right_paddle_y,
               frame_valid, overrun, frame_count, busy
    );

    modport slave (
        output enable, data_in, frame_ready,
        input  sel_out, ball_x, ball_y, left_paddle_y, right_paddle_y,
               frame_valid, overrun, frame_count, busy
    );

endinterface

// File: rtl/pong_settle_timer.sv
// Per-slot settle counter: done_o flags the cycle where timer == SETTLE_CYCLES.
// One register stage; load_i wins over count_i, no backpressure.
module pong_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    logic [3:0] timer_q;
    logic [3:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load_i) begin
            timer_d = '0;
        end else if (count_i) begin
            timer_d = timer_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign done_o = (timer_q == 4'(SETTLE_CYCLES));

endmodule

// File: rtl/pong_state_reader.sv
// Scans the core's four state slots into a shadow frame and presents it on a valid/ready port.
// Frame latency 4*(SETTLE_CYCLES+1)+1 cycles; a frame finishing while the previous is unaccepted is dropped.
module pong_state_reader
    import pong_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pong_state_reader_if.master  bus
);

    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [DATA_W-1:0] shadow_q [4];
    logic [DATA_W-1:0] frame_q  [4];
    logic              frame_valid_q, frame_valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic timer_load;
    logic timer_count;
    logic timer_done;
    logic shadow_we;
    logic commit;
    logic accept;
    logic load_frame;

    pong_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (timer_load),
        .count_i (timer_count),
        .done_o  (timer_done)
    );

    // enable is only looked at in IDLE and COMMIT, so a started frame always completes
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        timer_load  = 1'b1;
        timer_count = 1'b0;
        shadow_we   = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = SLOT;
                    slot_d  = SEL_BALL_X;
                end
            end
            SLOT: begin
                timer_load  = 1'b0;
                timer_count = 1'b1;
                if (timer_done) begin
                    shadow_we  = 1'b1;
                    timer_load = 1'b1;
                    if (slot_q == SEL_RIGHT_PAD) begin
                        state_d = COMMIT;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            COMMIT: begin
                commit = 1'b1;
                if (bus.enable) begin
                    state_d = SLOT;
                    slot_d  = SEL_BALL_X;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A commit may replace a frame only if the slot is empty or being accepted this cycle
    always_comb begin
        accept        = frame_valid_q && bus.frame_ready;
        load_frame    = commit && (!frame_valid_q || bus.frame_ready);
        frame_valid_d = load_frame || (frame_valid_q && !accept);
        overrun_d     = commit && !load_frame;
        frame_count_d = load_frame ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= SEL_BALL_X;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                frame_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            if (shadow_we) begin
                shadow_q[slot_q] <= bus.data_in;
            end
            if (load_frame) begin
                frame_q <= shadow_q;
            end
        end
    end

    assign bus.sel_out        = slot_q;
    assign bus.ball_x         = frame_q[SEL_BALL_X];
    assign bus.ball_y         = frame_q[SEL_BALL_Y];
    assign bus.left_paddle_y  = frame_q[SEL_LEFT_PAD];
    assign bus.right_paddle_y = frame_q[SEL_RIGHT_PAD];
    assign bus.frame_valid    = frame_valid_q;
    assign bus.overrun        = overrun_q;
    assign bus.frame_count    = frame_count_q;
    assign bus.busy           = (state_q != IDLE);

endmodule
